// File: rtl/cache_control_wb.sv
// rtl/cache_control_wb.sv - direct-mapped data cache controller, write-through or write-back
// Sequences CPU hits, line evict/fill and write-through beats; tag/data/valid/dirty storage is external.
module cache_control_wb #(
    parameter int  WAIT_CYCLES = 4,
    parameter int  LINE_WORDS  = 1,
    parameter int  WRITE_BACK  = 0,
    localparam int IDX_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Strobe,
    input  logic             DRW,
    input  logic             M,
    input  logic             V,
    input  logic             D,
    output logic             DReady,
    output logic             W,
    output logic             WSel,
    output logic             RSel,
    output logic             WTag,
    output logic             SetDirty,
    output logic             ClrDirty,
    output logic             MStrobe,
    output logic             MRW,
    output logic             MAddrSel,
    output logic [IDX_W-1:0] WordIdx,
    output logic             Busy
);

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WB_START, WB_WAIT, FILL_START,
        FILL_WAIT, FILL_WRITE, WT_START, WT_WAIT, DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [7:0]       WAIT_LD  = 8'(WAIT_CYCLES);
    localparam bit               WB_EN    = (WRITE_BACK != 0);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             hit;
    logic             last_word;

    assign hit       = M & V;
    assign last_word = (idx_q == LAST_IDX);
    assign WordIdx   = idx_q;
    assign Busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        DReady   = 1'b0;
        W        = 1'b0;
        WSel     = 1'b0;
        RSel     = 1'b0;
        WTag     = 1'b0;
        SetDirty = 1'b0;
        ClrDirty = 1'b0;
        MStrobe  = 1'b0;
        MRW      = 1'b0;
        MAddrSel = 1'b0;

        case (state_q)
            IDLE: begin
                if (Strobe) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (!DRW && hit) begin
                    DReady  = 1'b1;
                    state_d = IDLE;
                end else if (DRW && WB_EN && hit) begin
                    W        = 1'b1;
                    SetDirty = 1'b1;
                    DReady   = 1'b1;
                    state_d  = IDLE;
                end else if (DRW && !WB_EN) begin
                    // Write-through updates the cache only on a hit; misses never allocate.
                    W       = hit;
                    state_d = WT_START;
                end else begin
                    idx_d   = '0;
                    state_d = (WB_EN && V && D) ? WB_START : FILL_START;
                end
            end
            WB_START: begin
                MStrobe  = 1'b1;
                MRW      = 1'b1;
                MAddrSel = 1'b1;
                RSel     = 1'b1;
                cnt_d    = WAIT_LD;
                state_d  = WB_WAIT;
            end
            WB_WAIT: begin
                MRW      = 1'b1;
                MAddrSel = 1'b1;
                RSel     = 1'b1;
                cnt_d    = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = FILL_START;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = WB_START;
                    end
                end
            end
            FILL_START: begin
                MStrobe = 1'b1;
                cnt_d   = WAIT_LD;
                state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = FILL_WRITE;
            end
            FILL_WRITE: begin
                W    = 1'b1;
                WSel = 1'b1;
                if (last_word) begin
                    // A write miss returns to LOOKUP, where the freshly tagged line replays as a hit.
                    WTag     = 1'b1;
                    ClrDirty = 1'b1;
                    idx_d    = '0;
                    state_d  = DRW ? LOOKUP : DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = FILL_START;
                end
            end
            WT_START: begin
                MStrobe = 1'b1;
                MRW     = 1'b1;
                cnt_d   = WAIT_LD;
                state_d = WT_WAIT;
            end
            WT_WAIT: begin
                MRW   = 1'b1;
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = DONE;
            end
            DONE: begin
                DReady  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_control_wb.sv
// tb/tb_cache_control_wb.sv - randomized bench for cache_control_wb against a per-request trace model
// Two instances: write-through (LINE=1, WAIT=4) and write-back (LINE=4, WAIT=2).
`timescale 1ns/1ps
module tb_cache_control_wb;

    localparam int WB0 = 0, LN0 = 1, WT0 = 4;
    localparam int WB1 = 1, LN1 = 4, WT1 = 2;

    typedef struct {
        int          cyc;
        logic [15:0] v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic strobe0, drw0, m0, v0, d0;
    logic strobe1, drw1, m1, v1, d1;
    logic dready0, w0, wsel0, rsel0, wtag0, setd0, clrd0, mstb0, mrw0, maddr0, busy0;
    logic dready1, w1, wsel1, rsel1, wtag1, setd1, clrd1, mstb1, mrw1, maddr1, busy1;
    logic [0:0]  widx0;
    logic [1:0]  widx1;
    logic [15:0] obs0, obs1;

    // Bit map: 15 DReady 14 W 13 WSel 12 RSel 11 WTag 10 SetDirty 9 ClrDirty 8 MStrobe 7 MRW 6 MAddrSel 5 Busy 3:0 WordIdx
    assign obs0 = {dready0, w0, wsel0, rsel0, wtag0, setd0, clrd0, mstb0, mrw0, maddr0, busy0, 1'b0, 3'b000, widx0};
    assign obs1 = {dready1, w1, wsel1, rsel1, wtag1, setd1, clrd1, mstb1, mrw1, maddr1, busy1, 1'b0, 2'b00, widx1};

    cache_control_wb #(.WAIT_CYCLES(WT0), .LINE_WORDS(LN0), .WRITE_BACK(WB0)) u_wt (
        .clk(clk), .reset(reset), .Strobe(strobe0), .DRW(drw0), .M(m0), .V(v0), .D(d0),
        .DReady(dready0), .W(w0), .WSel(wsel0), .RSel(rsel0), .WTag(wtag0), .SetDirty(setd0),
        .ClrDirty(clrd0), .MStrobe(mstb0), .MRW(mrw0), .MAddrSel(maddr0), .WordIdx(widx0), .Busy(busy0)
    );

    cache_control_wb #(.WAIT_CYCLES(WT1), .LINE_WORDS(LN1), .WRITE_BACK(WB1)) u_wb (
        .clk(clk), .reset(reset), .Strobe(strobe1), .DRW(drw1), .M(m1), .V(v1), .D(d1),
        .DReady(dready1), .W(w1), .WSel(wsel1), .RSel(rsel1), .WTag(wtag1), .SetDirty(setd1),
        .ClrDirty(clrd1), .MStrobe(mstb1), .MRW(mrw1), .MAddrSel(maddr1), .WordIdx(widx1), .Busy(busy1)
    );

    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;
    bit          armed    = 1'b0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] tr[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] ev(input bit dr, input bit w, input bit ws, input bit rs,
                                       input bit wt, input bit sd, input bit cd, input bit ms,
                                       input bit mrw, input bit ma, input int idx);
        return {dr, w, ws, rs, wt, sd, cd, ms, mrw, ma, 1'b1, 1'b0, idx[3:0]};
    endfunction

    // Expected per-cycle outputs of one request, starting with the cycle after Strobe is taken.
    function automatic void build(input int wb, input int line, input int wt,
                                  input bit drw, input bit m, input bit v, input bit d);
        bit hit;
        bit last;
        hit = m & v;
        tr.delete();
        if (!drw && hit) begin
            tr.push_back(ev(1,0,0,0,0,0,0,0,0,0,0));
            return;
        end
        if (drw && wb != 0 && hit) begin
            tr.push_back(ev(1,1,0,0,0,1,0,0,0,0,0));
            return;
        end
        if (drw && wb == 0) begin
            tr.push_back(ev(0,hit,0,0,0,0,0,0,0,0,0));
            tr.push_back(ev(0,0,0,0,0,0,0,1,1,0,0));
            repeat (wt) tr.push_back(ev(0,0,0,0,0,0,0,0,1,0,0));
            tr.push_back(ev(1,0,0,0,0,0,0,0,0,0,0));
            return;
        end
        tr.push_back(ev(0,0,0,0,0,0,0,0,0,0,0));
        if (wb != 0 && v && d) begin
            for (int i = 0; i < line; i++) begin
                tr.push_back(ev(0,0,0,1,0,0,0,1,1,1,i));
                repeat (wt) tr.push_back(ev(0,0,0,1,0,0,0,0,1,1,i));
            end
        end
        for (int i = 0; i < line; i++) begin
            last = (i == line - 1);
            tr.push_back(ev(0,0,0,0,0,0,0,1,0,0,i));
            repeat (wt) tr.push_back(ev(0,0,0,0,0,0,0,0,0,0,i));
            tr.push_back(ev(0,1,1,0,last,0,last,0,0,0,i));
        end
        if (drw) tr.push_back(ev(1,1,0,0,0,1,0,0,0,0,0));
        else     tr.push_back(ev(1,0,0,0,0,0,0,0,0,0,0));
    endfunction

    function automatic int first_cyc(input int b);
        foreach (tr[i]) if (tr[i][b]) return i + 1;
        return -1;
    endfunction

    function automatic int count_set(input int b);
        int n = 0;
        foreach (tr[i]) if (tr[i][b]) n++;
        return n;
    endfunction

    task automatic set_strobe(input int dut, input bit s);
        if (dut == 0) strobe0 = s;
        else          strobe1 = s;
    endtask

    task automatic set_line(input int dut, input bit drw, input bit m, input bit v, input bit d);
        if (dut == 0) begin drw0 = drw; m0 = m; v0 = v; d0 = d; end
        else          begin drw1 = drw; m1 = m; v1 = v; d1 = d; end
    endtask

    // Issues one request on the selected instance; abort_at >= 0 asserts reset in that trace cycle.
    task automatic run_req(input int dut, input bit drw, input bit m, input bit v, input bit d,
                           input int abort_at);
        exp_t e;
        int   n;
        bit   lm, lv, ld;
        lm = m; lv = v; ld = d;
        if (dut == 0) build(WB0, LN0, WT0, drw, m, v, d);
        else          build(WB1, LN1, WT1, drw, m, v, d);
        n = tr.size();
        for (int i = 0; i < n; i++) begin
            e.cyc = cyc + 1 + i;
            e.v   = tr[i];
            if (dut == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        set_line(dut, drw, lm, lv, ld);
        set_strobe(dut, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                set_strobe(dut, 1'b0);
                while (q0.size() > 0 && q0[$].cyc > cyc) void'(q0.pop_back());
                while (q1.size() > 0 && q1[$].cyc > cyc) void'(q1.pop_back());
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                lit("abort_outputs_zero", (dut == 0) ? obs0 : obs1, 32'h0);
                @(posedge clk); #1;
                return;
            end
            set_strobe(dut, 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
            // External tag/valid/dirty storage reacts to the strobes of the previous cycle.
            if (tr[i][11]) begin lm = 1'b1; lv = 1'b1; end
            if (tr[i][9])  ld = 1'b0;
            if (tr[i][10]) ld = 1'b1;
            set_line(dut, drw, lm, lv, ld);
        end
        set_strobe(dut, 1'b0);
    endtask

    always @(negedge clk) begin
        if (armed) begin : cmp
            exp_t        e;
            logic [15:0] x0, x1;
            x0 = '0;
            x1 = '0;
            if (q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); x0 = e.v; end
            if (q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); x1 = e.v; end
            checks++;
            if (obs0 !== x0) begin
                failures++;
                $display("FAIL outputs_wt cyc=%0d got=%h expected=%h", cyc, obs0, x0);
            end
            checks++;
            if (obs1 !== x1) begin
                failures++;
                $display("FAIL outputs_wb cyc=%0d got=%h expected=%h", cyc, obs1, x1);
            end
        end
    end

    initial begin
        reset = 1'b1;
        strobe0 = 1'b0; drw0 = 1'b0; m0 = 1'b0; v0 = 1'b0; d0 = 1'b0;
        strobe1 = 1'b0; drw1 = 1'b0; m1 = 1'b0; v1 = 1'b0; d1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        lit("reset_outputs_wt", obs0, 32'h0);
        lit("reset_outputs_wb", obs1, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        armed = 1'b1;

        build(WB0, LN0, WT0, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("pin_rdmiss_len", tr.size(), 8);
        lit("pin_rdmiss_mstrobe_cyc", first_cyc(8), 2);
        lit("pin_rdmiss_wtag_cyc", first_cyc(11), 7);
        lit("pin_rdmiss_dready_cyc", first_cyc(15), 8);
        build(WB0, LN0, WT0, 1'b1, 1'b0, 1'b0, 1'b0);
        lit("pin_wtmiss_dready_cyc", first_cyc(15), 7);
        lit("pin_wtmiss_w_count", count_set(14), 0);
        build(WB1, LN1, WT1, 1'b1, 1'b0, 1'b1, 1'b1);
        lit("pin_wbmiss_len", tr.size(), 30);
        lit("pin_wbmiss_mstrobe_count", count_set(8), 8);
        lit("pin_wbmiss_last_fill", tr[28], 32'h6A23);
        lit("pin_wbmiss_replay", tr[29], 32'hC420);

        run_req(0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        run_req(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_req(0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        run_req(0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        run_req(1, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        run_req(1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        run_req(1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        run_req(1, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        run_req(1, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        repeat (250) begin
            run_req($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        lit("queues_drained", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
